lights_selector_multi: RTL and testbench
========================================

Name: lights_selector_multi

Overview:
- Parametrised successor to the single-RGB lights selector.
- Drives N_CH RGB light channels from one shared colour sequencer. The sequencer has four modes: white, manual step, auto step and off.
- Channel k shows the sequence colour offset by k positions, so multiple channels produce a chase effect.
- Sits between the board push-button and mode switches and the LED driver bus.

Parameters:
- N_CH, 2, number of RGB channels (1..6).
- CH_BITS, 8, bits per colour component.
- AUTO_DIV, 50000000, clock cycles per step in auto mode (>=2).
- FADE_STEP, 16, per-cycle component increment/decrement; used only with LIGHTS_FADE_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  2  00 white, 01 manual, 10 auto, 11 off.
- button  in  1  asynchronous push-button, active high.
- light  out  N_CH*3*CH_BITS  channel k occupies bits [(k+1)*3*CH_BITS-1 : k*3*CH_BITS]. Within a channel: blue [CH_BITS-1:0], green next, red top.
- wrap  out  1  one-cycle pulse when the sequence index steps from 6 to 1.

Behaviour:
- Colour codes are {R,G,B}. Sequence index idx cycles 1→2→3→4→5→6→1 (001 blue … 110 yellow). Codes 000 and 111 are never produced by the sequencer.
- Channel k colour code = ((idx-1+k) mod 6)+1. Each component is all-ones if its code bit is 1, else zero.
- Reset (rst_n low, asynchronous):
  - idx=1, auto counter=0, synchroniser flops=0, wrap=0.
  - light = all channels at their reset code, i.e. channel 0 = blue = {0,0,all-ones}.
- Button path:
  - 2-flop synchroniser (s1,s2), then s3 for edge detect.
  - step_req = s2 & ~s3.
  - A button held high from before rising edge e1 gives step_req true at e3; idx updates at e3; light updates at e4.
  - Holding the button gives exactly one step. Re-pressing requires a low period of at least 2 cycles to be seen.
- Mode 01 (manual): idx advances on step_req only; auto counter held at 0.
- Mode 10 (auto):
  - Counter counts 0..AUTO_DIV-1; idx advances on the cycle the counter equals AUTO_DIV-1, and the counter returns to 0.
  - button is ignored.
  - Counter clears to 0 on any cycle where registered mode != 10.
- Mode 00: all light bits 1; idx holds.
- Mode 11: all light bits 0; idx holds.
- Modes 00 and 11 discard step_req.
- light is fully registered: it reflects mode and idx one cycle after they change.
- wrap = 1 for exactly the cycle after idx goes 6→1, aligned with the light update.
- A mode change on the same edge as a step: the step uses the mode sampled on that edge.
- Reset mid-operation clears everything immediately, regardless of clk.

Optional Feature:
- LIGHTS_FADE_EN defined:
  - Each output component register moves toward its target by FADE_STEP per cycle, saturating exactly at the target with no overshoot.
  - The reset value is still the immediate target value.
  - wrap timing is unchanged (tied to idx, not to the fade).
- Undefined: components jump to target in one cycle as described above. FADE_STEP is unused.

Test Plan (N_CH=2, CH_BITS=8, AUTO_DIV=4):
- Reset with mode=01: rst_n low → light=48'h00FF00_0000FF (ch1 green, ch0 blue), wrap=0. Release; light holds with no button.
- Manual step: button high 1 cycle-aligned, then held 10 cycles → exactly one step. Light becomes 48'h00FFFF_00FF00 on the 4th edge after assertion. Second press after ≥2 low cycles → 48'hFF0000_00FFFF.
- Wrap: 6 presses from reset → idx back to 1, light=48'h00FF00_0000FF. wrap high exactly one cycle on that update; never high otherwise.
- Auto mode: mode=10, button toggling → idx steps every 4 cycles, button has no effect. Switch to 01 for 1 cycle and back → counter restarts, next step 4 cycles later.
- Mode 00 / 11: light=48'hFFFFFF_FFFFFF / 48'h0. Button presses are ignored. Returning to 01 restores the pre-switch colour.
- Async reset mid-auto: drop rst_n between clock edges → light=48'h00FF00_0000FF before the next edge. With LIGHTS_FADE_EN and FADE_STEP=16, a 00→FF component transition takes 16 cycles.

Source files
------------

// File: rtl/lights_selector_multi.sv
// Shared colour sequencer driving N_CH RGB channels with a per-channel chase offset.
// Define LIGHTS_FADE_EN to ramp each component toward its target by FADE_STEP per cycle.
module lights_selector_multi #(
   parameter int N_CH      = 2,
   parameter int CH_BITS   = 8,
   parameter int AUTO_DIV  = 50000000,
   parameter int FADE_STEP = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [1:0]                mode,
   input  logic                      button,
   output logic [N_CH*3*CH_BITS-1:0] light,
   output logic                      wrap
);

   localparam int LW    = N_CH * 3 * CH_BITS;
   localparam int CNT_W = $clog2(AUTO_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AUTO_DIV - 1);
   localparam logic [2:0]       IDX_FIRST = 3'd1;
   localparam logic [2:0]       IDX_LAST  = 3'd6;

   typedef enum logic [1:0] {
      MODE_WHITE  = 2'b00,
      MODE_MANUAL = 2'b01,
      MODE_AUTO   = 2'b10,
      MODE_OFF    = 2'b11
   } mode_e;

   if (N_CH < 1 || N_CH > 6 || CH_BITS < 1 || AUTO_DIV < 2 || FADE_STEP < 1) begin : g_bad_param
      $error("lights_selector_multi: parameter out of range");
   end

   // Channel k shows the sequence colour k positions ahead, wrapping within 1..6.
   function automatic logic [2:0] chan_code(input logic [2:0] seq_idx, input int k);
      int pos;
      pos = (int'(seq_idx) - 1 + k) % 6;
      return 3'(pos + 1);
   endfunction

   function automatic logic [LW-1:0] seq_pattern(input logic [2:0] seq_idx);
      logic [LW-1:0] pat;
      logic [2:0]    code;
      pat = '0;
      for (int k = 0; k < N_CH; k++) begin
         code = chan_code(seq_idx, k);
         pat[k*3*CH_BITS             +: CH_BITS] = {CH_BITS{code[0]}};
         pat[k*3*CH_BITS + CH_BITS   +: CH_BITS] = {CH_BITS{code[1]}};
         pat[k*3*CH_BITS + 2*CH_BITS +: CH_BITS] = {CH_BITS{code[2]}};
      end
      return pat;
   endfunction

   localparam logic [LW-1:0] RESET_LIGHT = seq_pattern(IDX_FIRST);

   mode_e mode_sel;
   assign mode_sel = mode_e'(mode);

   // ------------------------------------------------------------------
   // Button synchroniser and rising-edge detect
   // ------------------------------------------------------------------
   logic s1, s2, s3;
   logic step_req;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; blocking here would collapse the synchroniser chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= button;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign step_req = s2 & ~s3;

   // ------------------------------------------------------------------
   // Sequencer: index and auto-step divider
   // ------------------------------------------------------------------
   logic [2:0]       idx, idx_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             advance;
   logic             wrap_pend;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx       <= IDX_FIRST;
         cnt       <= '0;
         wrap_pend <= 1'b0;
      end else begin
         idx       <= idx_next;
         cnt       <= cnt_next;
         wrap_pend <= advance && (idx == IDX_LAST);
      end
   end

   // NOTE: every signal gets a default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      advance  = 1'b0;
      cnt_next = '0;
      case (mode_sel)
         MODE_MANUAL: advance = step_req;
         MODE_AUTO: begin
            if (cnt == CNT_LAST) advance = 1'b1;
            else                 cnt_next = cnt + 1'b1;
         end
         default: ;
      endcase

      idx_next = idx;
      if (advance) idx_next = (idx == IDX_LAST) ? IDX_FIRST : idx + 3'd1;
   end

   // ------------------------------------------------------------------
   // Output stage: target colour, optional fade, registered light bus
   // ------------------------------------------------------------------
   logic [LW-1:0] target;
   logic [LW-1:0] light_next;
   logic [LW-1:0] light_q;
   logic          wrap_q;

   always_comb begin
      case (mode_sel)
         MODE_WHITE: target = '1;
         MODE_OFF:   target = '0;
         default:    target = seq_pattern(idx);
      endcase
   end

`ifdef LIGHTS_FADE_EN
   localparam logic [CH_BITS-1:0] STEP = CH_BITS'(FADE_STEP);

   // Each component closes on its target by STEP, landing exactly on it.
   always_comb begin
      logic [CH_BITS-1:0] cur;
      logic [CH_BITS-1:0] tgt;
      light_next = light_q;
      cur        = '0;
      tgt        = '0;
      for (int c = 0; c < N_CH * 3; c++) begin
         cur = light_q[c*CH_BITS +: CH_BITS];
         tgt = target[c*CH_BITS +: CH_BITS];
         if (tgt > cur)
            light_next[c*CH_BITS +: CH_BITS] = ((tgt - cur) <= STEP) ? tgt : cur + STEP;
         else if (cur > tgt)
            light_next[c*CH_BITS +: CH_BITS] = ((cur - tgt) <= STEP) ? tgt : cur - STEP;
      end
   end
`else
   assign light_next = target;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         light_q <= RESET_LIGHT;
         wrap_q  <= 1'b0;
      end else begin
         light_q <= light_next;
         wrap_q  <= wrap_pend;
      end
   end

   assign light = light_q;
   assign wrap  = wrap_q;

endmodule

// File: tb/tb_lights_selector_multi.sv
// Directed bench for lights_selector_multi (N_CH=2, CH_BITS=8, AUTO_DIV=4).
// Table of constant-input segments, each edge checked against hand-computed light/wrap.
module tb_lights_selector_multi;

   localparam logic [47:0] L1   = 48'h00FF00_0000FF;
   localparam logic [47:0] L2   = 48'h00FFFF_00FF00;
   localparam logic [47:0] L3   = 48'hFF0000_00FFFF;
   localparam logic [47:0] L4   = 48'hFF00FF_FF0000;
   localparam logic [47:0] L5   = 48'hFFFF00_FF00FF;
   localparam logic [47:0] L6   = 48'h0000FF_FFFF00;
   localparam logic [47:0] ALL1 = 48'hFFFFFF_FFFFFF;
   localparam logic [47:0] ALL0 = 48'h0;

   typedef struct {
      logic [1:0]  mode;
      logic        button;
      int          cycles;
      logic [47:0] light;
      logic        wrap;
   } seg_t;

   logic        clk;
   logic        rst_n;
   logic [1:0]  mode;
   logic        button;
   logic [47:0] light;
   logic        wrap;

   int   n_checks;
   int   n_fail;
   seg_t segs[$];

   lights_selector_multi #(
      .N_CH     (2),
      .CH_BITS  (8),
      .AUTO_DIV (4),
      .FADE_STEP(16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .mode  (mode),
      .button(button),
      .light (light),
      .wrap  (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic [1:0] m, input logic b, input int n,
                      input logic [47:0] l, input logic w);
      seg_t s;
      s.mode   = m;
      s.button = b;
      s.cycles = n;
      s.light  = l;
      s.wrap   = w;
      segs.push_back(s);
   endtask

   // A manual press: three edges of latency, new colour on the fourth, then release.
   task automatic press(input logic [47:0] from, input logic [47:0] to, input logic w);
      add(2'b01, 1'b1, 3, from, 1'b0);
      add(2'b01, 1'b1, 1, to,   w);
      add(2'b01, 1'b0, 3, to,   1'b0);
   endtask

   task automatic run_seg(input seg_t s, input int id);
      for (int c = 0; c < s.cycles; c++) begin
         @(negedge clk);
         mode   = s.mode;
         button = s.button;
         @(posedge clk);
         #1;
         check($sformatf("seg%0d.%0d light", id, c), light, s.light);
         check($sformatf("seg%0d.%0d wrap", id, c), {47'b0, wrap}, {47'b0, s.wrap});
      end
   endtask

   initial begin
      seg_t tail;
      n_checks = 0;
      n_fail   = 0;

      // Idle, then a press held for ten cycles giving exactly one step.
      add(2'b01, 1'b0, 3, L1, 1'b0);
      add(2'b01, 1'b1, 3, L1, 1'b0);
      add(2'b01, 1'b1, 1, L2, 1'b0);
      add(2'b01, 1'b1, 6, L2, 1'b0);
      add(2'b01, 1'b0, 3, L2, 1'b0);
      press(L2, L3, 1'b0);
      press(L3, L4, 1'b0);
      press(L4, L5, 1'b0);
      press(L5, L6, 1'b0);
      press(L6, L1, 1'b1);
      press(L1, L2, 1'b0);
      // White and off ignore the button; manual restores the held colour.
      add(2'b00, 1'b0, 1, ALL1, 1'b0);
      add(2'b00, 1'b1, 4, ALL1, 1'b0);
      add(2'b00, 1'b0, 3, ALL1, 1'b0);
      add(2'b11, 1'b0, 1, ALL0, 1'b0);
      add(2'b11, 1'b1, 4, ALL0, 1'b0);
      add(2'b11, 1'b0, 3, ALL0, 1'b0);
      add(2'b01, 1'b0, 3, L2, 1'b0);
      // Auto with the button toggling: a step every four edges.
      add(2'b10, 1'b1, 2, L2, 1'b0);
      add(2'b10, 1'b0, 2, L2, 1'b0);
      add(2'b10, 1'b1, 2, L3, 1'b0);
      add(2'b10, 1'b0, 2, L3, 1'b0);
      add(2'b10, 1'b1, 2, L4, 1'b0);
      add(2'b10, 1'b0, 2, L4, 1'b0);
      add(2'b10, 1'b0, 2, L5, 1'b0);
      // One manual cycle mid-count restarts the divider.
      add(2'b01, 1'b0, 1, L5, 1'b0);
      add(2'b10, 1'b0, 4, L5, 1'b0);
      add(2'b10, 1'b0, 4, L6, 1'b0);
      add(2'b10, 1'b0, 1, L1, 1'b1);
      add(2'b10, 1'b0, 3, L1, 1'b0);
      add(2'b10, 1'b0, 1, L2, 1'b0);

      // Reset asserted before any clock edge.
      mode   = 2'b01;
      button = 1'b0;
      rst_n  = 1'b1;
      #3 rst_n = 1'b0;
      #1;
      check("reset light", light, L1);
      check("reset wrap", {47'b0, wrap}, 48'h0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < segs.size(); i++) run_seg(segs[i], i);

      // Asynchronous reset mid-auto, between edges.
      #2 rst_n = 1'b0;
      #1;
      check("async reset light", light, L1);
      check("async reset wrap", {47'b0, wrap}, 48'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // After reset the index is back at 1: one press lands on L2.
      tail.wrap = 1'b0;
      tail.mode = 2'b01;
      tail.button = 1'b0; tail.cycles = 3; tail.light = L1; run_seg(tail, 100);
      tail.button = 1'b1; tail.cycles = 3; tail.light = L1; run_seg(tail, 101);
      tail.button = 1'b1; tail.cycles = 1; tail.light = L2; run_seg(tail, 102);
      tail.button = 1'b0; tail.cycles = 3; tail.light = L2; run_seg(tail, 103);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
